// File: rtl/mul_feeder_pkg.sv
// Shared types and widths for the multiplier operand feeder.
// No logic lives here; it only holds declarations.
// Used by the FIFO, the interface and the top-level FSM.
package mul_feeder_pkg;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

  // Issue-side state machine
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  // One queued operand pair; A sits in the upper byte of a FIFO word
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } pair_t;

  // Product of one pair; used for readability where a model is handy
  function automatic logic [PRODW-1:0] pair_product(input pair_t p);
    return PRODW'(p.a) * PRODW'(p.b);
  endfunction

endpackage

// File: rtl/mul_operand_feeder_if.sv
// Bundle of producer, multiplier and result signals of the operand feeder.
// master = the feeder itself; slave = the environment around it.
// Pure wiring, no latency and no flow control of its own.
interface mul_operand_feeder_if
  import mul_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int LVLW = $clog2(DEPTH) + 1;

  // producer side
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_a;
  logic [OPW-1:0]   in_b;
  // multiplier side
  logic             mul_start;
  logic [OPW-1:0]   mul_a;
  logic [OPW-1:0]   mul_b;
  logic             mul_done;
  logic [PRODW-1:0] mul_product;
  // result side and status
  logic             res_valid;
  logic [OPW-1:0]   res_a;
  logic [OPW-1:0]   res_b;
  logic [PRODW-1:0] res_product;
  logic             busy;
  logic [LVLW-1:0]  level;

  modport master (
    input  in_valid, in_a, in_b, mul_done, mul_product,
    output in_ready, mul_start, mul_a, mul_b,
           res_valid, res_a, res_b, res_product, busy, level
  );

  modport slave (
    output in_valid, in_a, in_b, mul_done, mul_product,
    input  in_ready, mul_start, mul_a, mul_b,
           res_valid, res_a, res_b, res_product, busy, level
  );

endinterface

// File: rtl/mul_feeder_fifo.sv
// Circular-buffer sync FIFO holding packed operand pairs.
// Latency: a push is visible at the head one cycle later; head is read combinationally.
// Backpressure: full_o gates pushes (ignored when full); pops on empty are ignored.
module mul_feeder_fifo
  import mul_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LVLW = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (level_q == LVLW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap by overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVLW'(1);
      2'b01:   level_d = level_q - LVLW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while the entry is not valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mul_operand_feeder.sv
// Issue stage for the 8x8 sequential multiplier: queues pairs, launches one at a time, returns product beats.
// Latency: push into idle/empty block -> mul_start 2 cycles later; result beat 1 cycle after completion capture.
// Backpressure: in_ready = FIFO not full; no backpressure on res_*. Optional FIXED_LATENCY_EN times completion internally.
module mul_operand_feeder
  import mul_feeder_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mul_operand_feeder_if.master  bus
);

  localparam int LVLW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) || (MUL_LATENCY < 1))
  begin : g_bad_params
    $error("mul_operand_feeder: DEPTH must be a power of two in 2..16 and MUL_LATENCY >= 1");
  end

  state_e           state_q, state_d;
  logic [OPW-1:0]   hold_a_q, hold_a_d;
  logic [OPW-1:0]   hold_b_q, hold_b_d;
  logic [OPW-1:0]   res_a_q, res_a_d;
  logic [OPW-1:0]   res_b_q, res_b_d;
  logic [PRODW-1:0] res_prod_q, res_prod_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVLW-1:0]  fifo_level;
  pair_t            fifo_head;
  logic             op_complete;

  mul_feeder_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * OPW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .din_i   ({bus.in_a, bus.in_b}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifdef FIXED_LATENCY_EN
  localparam int CNTW = $clog2(MUL_LATENCY + 1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  // Completion timer: loaded on entry to ARM, counts down only in WAIT, fires at zero
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LAUNCH) begin
      cnt_d = CNTW'(MUL_LATENCY);
    end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  // Completion timer register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign op_complete = (cnt_q == '0);
`else
  // Completion is the multiplier's level done flag; the ARM cycle keeps a stale one out
  assign op_complete = bus.mul_done;
`endif

  // FSM next-state, FIFO pop and operand/result capture
  always_comb begin
    state_d    = state_q;
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    res_a_d    = res_a_q;
    res_b_d    = res_b_q;
    res_prod_d = res_prod_q;
    fifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_a_d = fifo_head.a;
          hold_b_d = fifo_head.b;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_ARM;
      S_ARM:    state_d = S_WAIT;
      S_WAIT: begin
        if (op_complete) begin
          res_a_d    = hold_a_q;
          res_b_d    = hold_b_q;
          res_prod_d = bus.mul_product;
          state_d    = S_RESULT;
        end
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state, held operands and captured result; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      res_a_q    <= '0;
      res_b_q    <= '0;
      res_prod_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      res_a_q    <= res_a_d;
      res_b_q    <= res_b_d;
      res_prod_q <= res_prod_d;
    end
  end

  assign bus.in_ready    = ~fifo_full;
  assign bus.level       = fifo_level;
  assign bus.mul_start   = (state_q == S_LAUNCH);
  assign bus.mul_a       = (state_q == S_LAUNCH) ? hold_a_q : '0;
  assign bus.mul_b       = (state_q == S_LAUNCH) ? hold_b_q : '0;
  assign bus.busy        = (state_q == S_LAUNCH) || (state_q == S_ARM) || (state_q == S_WAIT);
  assign bus.res_valid   = (state_q == S_RESULT);
  assign bus.res_a       = res_a_q;
  assign bus.res_b       = res_b_q;
  assign bus.res_product = res_prod_q;

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed bench for mul_operand_feeder with a behavioural sequential-multiplier stub.
// Inputs are driven 1ns after the rising edge; the result monitor samples on the falling edge.
// Stub modes: normal (level done), stale (done held high), dead (done held low, fixed-latency build).
module tb_mul_operand_feeder;

  localparam int DEPTH    = 4;
  localparam int STUB_LAT = 6;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mul_operand_feeder_if #(.DEPTH(DEPTH)) bus ();

  mul_operand_feeder #(
    .DEPTH       (DEPTH),
    .MUL_LATENCY (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else             n_pass++;
  endtask

  // ---------------- multiplier stub ----------------
  bit          stale_mode = 1'b0;
  bit          dead_mode  = 1'b0;
  logic [7:0]  lat_a, lat_b;
  logic        stub_done;
  logic [15:0] stub_prod;
  int          stub_cnt;

  always @(posedge clk) begin
    if (rst) begin
      stub_done <= 1'b1;
      stub_prod <= 16'h0;
      stub_cnt  <= 0;
      lat_a     <= 8'h0;
      lat_b     <= 8'h0;
    end else if (bus.mul_start) begin
      lat_a     <= bus.mul_a;
      lat_b     <= bus.mul_b;
      stub_done <= 1'b0;
      stub_cnt  <= STUB_LAT;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_prod <= 16'(lat_a) * 16'(lat_b);
      end
    end
  end

  assign bus.mul_done    = dead_mode ? 1'b0 : (stale_mode ? 1'b1 : stub_done);
  assign bus.mul_product = stale_mode ? 16'(lat_a) * 16'(lat_b) : stub_prod;

  // ---------------- scoreboard / monitor ----------------
  vec_t launch_q[$];
  vec_t exp_q[$];
  vec_t mon_v;
  int   n_start       = 0;
  int   n_res         = 0;
  int   exp_total     = 0;
  int   unexp_start   = 0;
  int   unexp_res     = 0;
  int   idle_nonzero  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mul_start) begin
        n_start++;
        if (launch_q.size() == 0) unexp_start++;
        else begin
          mon_v = launch_q.pop_front();
          check("mul_a", bus.mul_a, mon_v.a);
          check("mul_b", bus.mul_b, mon_v.b);
        end
      end else if ((bus.mul_a != 8'h0) || (bus.mul_b != 8'h0)) begin
        idle_nonzero++;
      end
      if (bus.res_valid) begin
        n_res++;
        if (exp_q.size() == 0) unexp_res++;
        else begin
          mon_v = exp_q.pop_front();
          check("res_a", bus.res_a, mon_v.a);
          check("res_b", bus.res_b, mon_v.b);
          check("res_product", bus.res_product, mon_v.p);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input vec_t v);
    launch_q.push_back(v);
    exp_q.push_back(v);
    exp_total++;
  endtask

  // Drive one pair for exactly one cycle without waiting (caller handles deassert)
  task automatic drive(input vec_t v);
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_valid = 1'b1;
    enq(v);
    tick();
  endtask

  // Push with a bounded wait for in_ready
  task automatic push(input vec_t v);
    int k;
    for (k = 0; k < 400; k++) begin
      if (bus.in_ready) break;
      tick();
    end
    check("push_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    drive(v);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if ((exp_q.size() == 0) && !bus.busy && !bus.res_valid && (bus.level == '0)) break;
      tick();
    end
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  task automatic wait_start(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (bus.mul_start) break;
      tick();
    end
    check({"start_seen_", tag}, {31'b0, bus.mul_start}, 32'd1);
  endtask

  vec_t bnd_v[3];
  vec_t fill_v[5];
  vec_t rst_v[4];

  initial begin
    int base_start;
    int base_res;
    vec_t v;

    bnd_v[0] = {8'hFF, 8'hFF, 16'hFE01};
    bnd_v[1] = {8'h00, 8'hA5, 16'h0000};
    bnd_v[2] = {8'h01, 8'h80, 16'h0080};
    fill_v[0] = {8'h02, 8'h03, 16'h0006};
    fill_v[1] = {8'h10, 8'h10, 16'h0100};
    fill_v[2] = {8'h7F, 8'h02, 16'h00FE};
    fill_v[3] = {8'h0C, 8'h0D, 16'h009C};
    fill_v[4] = {8'hAA, 8'h02, 16'h0154};
    rst_v[0]  = {8'h01, 8'h01, 16'h0001};
    rst_v[1]  = {8'h02, 8'h02, 16'h0004};
    rst_v[2]  = {8'h03, 8'h03, 16'h0009};
    rst_v[3]  = {8'h04, 8'h04, 16'h0010};

    bus.in_valid = 1'b0;
    bus.in_a     = 8'h0;
    bus.in_b     = 8'h0;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) tick();
    check("rst_level", bus.level, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_res_product", bus.res_product, 0);
    rst = 1'b0;
    tick();

    // ---- single op and launch latency ----
    drive({8'h0F, 8'h11, 16'h00FF});
    bus.in_valid = 1'b0;
    check("lat_c1_start", bus.mul_start, 0);
    check("lat_c1_level", bus.level, 1);
    check("lat_c1_busy", bus.busy, 0);
    tick();
    check("lat_c2_start", bus.mul_start, 1);
    check("lat_c2_mul_a", bus.mul_a, 8'h0F);
    check("lat_c2_mul_b", bus.mul_b, 8'h11);
    check("lat_c2_busy", bus.busy, 1);
    check("lat_c2_level", bus.level, 0);
    drain("single", 100);
    check("single_held_product", bus.res_product, 16'h00FF);
    check("single_held_a", bus.res_a, 8'h0F);

    // ---- boundary operands ----
    for (int i = 0; i < 3; i++) push(bnd_v[i]);
    drain("boundary", 200);
    check("boundary_held_product", bus.res_product, 16'h0080);

    // ---- fill: 5 back-to-back pushes, then a push attempt while full ----
    for (int i = 0; i < 5; i++) drive(fill_v[i]);
    bus.in_valid = 1'b0;
    check("fill_level", bus.level, 4);
    check("fill_in_ready", bus.in_ready, 0);
    bus.in_a     = 8'hDE;
    bus.in_b     = 8'hAD;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("full_push_ignored_level", bus.level, 4);
    drain("fill", 300);
    check("fill_in_ready_after", bus.in_ready, 1);

`ifndef FIXED_LATENCY_EN
    // ---- stale done held high: capture in the cycle after ARM only ----
    stale_mode = 1'b1;
    push({8'h03, 8'h05, 16'h000F});
    wait_start("stale");
    tick();
    check("stale_arm_res_valid", bus.res_valid, 0);
    check("stale_arm_busy", bus.busy, 1);
    tick();
    check("stale_wait_res_valid", bus.res_valid, 0);
    tick();
    check("stale_result_valid", bus.res_valid, 1);
    check("stale_result_product", bus.res_product, 16'h000F);
    tick();
    check("stale_single_beat", bus.res_valid, 0);
    drain("stale", 100);
    stale_mode = 1'b0;
`endif

    // ---- reset mid-WAIT with 3 pairs queued ----
    for (int i = 0; i < 4; i++) drive(rst_v[i]);
    bus.in_valid = 1'b0;
    check("midrst_level_before", bus.level, 3);
    check("midrst_busy_before", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_level", bus.level, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    exp_total = exp_total - exp_q.size();
    launch_q.delete();
    exp_q.delete();
    base_start = n_start;
    base_res   = n_res;
    repeat (40) tick();
    check("midrst_no_start", n_start, base_start);
    check("midrst_no_res", n_res, base_res);

`ifdef FIXED_LATENCY_EN
    // ---- fixed latency: done tied low, result 13 cycles after start ----
    dead_mode = 1'b1;
    begin
      int k;
      push({8'h0F, 8'h11, 16'h00FF});
      wait_start("fixed");
      for (k = 0; k < 40; k++) begin
        if (bus.res_valid) break;
        tick();
      end
      check("fixed_latency", k, 13);
    end
    drain("fixed_single", 100);
    for (int i = 0; i < 100; i++) begin
      v.a = 8'($urandom_range(0, 255));
      v.b = 8'($urandom_range(0, 255));
      v.p = 16'(v.a) * 16'(v.b);
      push(v);
    end
    drain("fixed_random", 3000);
    dead_mode = 1'b0;
`endif

    // ---- global scoreboard checks ----
    check("unexpected_starts", unexp_start, 0);
    check("unexpected_results", unexp_res, 0);
    check("idle_mul_operands_zero", idle_nonzero, 0);
    check("result_beat_count", n_res, exp_total);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
